// File: rtl/matmul_nxn_seq.sv
// rtl/matmul_nxn_seq.sv - N x N unsigned matrix multiplier, one k term per cycle on N*N MAC lanes
// Optional saturating accumulation with sticky overflow: define MATMUL_SATURATE_EN.
module matmul_nxn_seq #(
  parameter int N      = 4,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*N*DATA_W-1:0]   a_flat,
  input  logic [N*N*DATA_W-1:0]   b_flat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N*N*ACC_W-1:0]    c_flat,
  output logic                    ovf
);

  localparam int K_W = (N > 2) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [N*N*DATA_W-1:0]   a_q, a_d;
  logic [N*N*DATA_W-1:0]   b_q, b_d;
  logic [N*N*ACC_W-1:0]    acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic [2*DATA_W-1:0]     prod;
`ifdef MATMUL_SATURATE_EN
  logic [ACC_W:0]          sum;
`endif

  // State, k counter, operand copies and accumulators; everything clears on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: accept in IDLE, one inner-product term per lane per COMPUTE cycle, hold in DONE
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    prod    = '0;
`ifdef MATMUL_SATURATE_EN
    sum     = '0;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a_flat;
          b_d     = b_flat;
          acc_d   = '0;
          ovf_d   = 1'b0;
          k_d     = '0;
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            prod = a_q[(i*N + int'(k_q))*DATA_W +: DATA_W] *
                   b_q[(int'(k_q)*N + j)*DATA_W +: DATA_W];
`ifdef MATMUL_SATURATE_EN
            sum = {1'b0, acc_q[(i*N + j)*ACC_W +: ACC_W]} + (ACC_W+1)'(prod);
            if (sum[ACC_W]) begin
              acc_d[(i*N + j)*ACC_W +: ACC_W] = '1;
              ovf_d = 1'b1;
            end else begin
              acc_d[(i*N + j)*ACC_W +: ACC_W] = sum[ACC_W-1:0];
            end
`else
            acc_d[(i*N + j)*ACC_W +: ACC_W] =
              acc_q[(i*N + j)*ACC_W +: ACC_W] + ACC_W'(prod);
`endif
          end
        end
        if (k_q == K_W'(N-1)) begin
          k_d     = '0;
          state_d = DONE;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign c_flat    = acc_q;
  assign ovf       = ovf_q;

endmodule
